// File: rtl/psum_accum_engine_if.sv
// ---------------------------------------------------------------------------
// psum_accum_engine_if
// Bundles the configuration, partial-sum beat and psum-buffer memory signals
// of psum_accum_engine. The engine connects through the slave modport; the
// environment that configures it, feeds beats and models the memory uses the
// master modport.
//
// Signal summary:
//   cfg_start/cfg_base_addr/cfg_len/cfg_num_pass : job configuration
//   psum_dat/psum_vld                             : partial-sum beats
//   mem_radd/mem_rden/mem_odat/mem_ovld           : buffer read port
//   mem_wadd/mem_wren/mem_idat                    : buffer write port
//   o_busy/o_done/o_pass_cnt                      : status
//   dbg_state                                     : FSM state (debug)
//
// Handshake semantics: psum_vld marks a beat that is consumed in the same
// cycle (no backpressure). mem_rden issues a read whose data arrives with
// mem_ovld exactly MEM_DELAY cycles later. mem_wren commits mem_idat to
// mem_wadd at the end of the cycle. A read and a write to the same address
// in one cycle return the pre-write contents.
// ---------------------------------------------------------------------------
interface psum_accum_engine_if #(
  parameter int NUM_KERNEL = 4,
  parameter int BIT_WIDTH  = 8,
  parameter int ACC_WIDTH  = 16,
  parameter int ADDR_WIDTH = 16
);
  logic                             cfg_start;
  logic [ADDR_WIDTH-1:0]            cfg_base_addr;
  logic [ADDR_WIDTH-1:0]            cfg_len;
  logic [15:0]                      cfg_num_pass;
  logic [NUM_KERNEL*BIT_WIDTH-1:0]  psum_dat;
  logic                             psum_vld;
  logic [ADDR_WIDTH-1:0]            mem_radd;
  logic                             mem_rden;
  logic [NUM_KERNEL*ACC_WIDTH-1:0]  mem_odat;
  logic                             mem_ovld;
  logic [ADDR_WIDTH-1:0]            mem_wadd;
  logic                             mem_wren;
  logic [NUM_KERNEL*ACC_WIDTH-1:0]  mem_idat;
  logic                             o_busy;
  logic                             o_done;
  logic [15:0]                      o_pass_cnt;
  logic [1:0]                       dbg_state;

  modport slave (
    input  cfg_start, cfg_base_addr, cfg_len, cfg_num_pass,
    input  psum_dat, psum_vld, mem_odat, mem_ovld,
    output mem_radd, mem_rden, mem_wadd, mem_wren, mem_idat,
    output o_busy, o_done, o_pass_cnt, dbg_state
  );

  modport master (
    output cfg_start, cfg_base_addr, cfg_len, cfg_num_pass,
    output psum_dat, psum_vld, mem_odat, mem_ovld,
    input  mem_radd, mem_rden, mem_wadd, mem_wren, mem_idat,
    input  o_busy, o_done, o_pass_cnt, dbg_state
  );
endinterface

// File: rtl/psum_accum_engine.sv
// ---------------------------------------------------------------------------
// psum_accum_engine
// Partial-sum accumulator for the conv datapath. Each psum_vld beat carries
// NUM_KERNEL signed lanes that are read-modify-written into the psum buffer
// over cfg_num_pass passes of cfg_len beats. Pass 0 overwrites the buffer,
// later passes add onto it. Writes still in flight are forwarded so that
// short passes never accumulate onto stale memory data.
//
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset (aborts a job immediately)
//   bus  : psum_accum_engine_if.slave (config, beats, memory, status)
//
// Build option: define PSUM_SAT_EN to saturate each lane add to the signed
// ACC_WIDTH range; otherwise lanes wrap modulo 2^ACC_WIDTH.
//
// Timing: a beat accepted in cycle t is written in cycle t+MEM_DELAY+1.
// ---------------------------------------------------------------------------
module psum_accum_engine #(
  parameter int NUM_KERNEL = 4,
  parameter int BIT_WIDTH  = 8,
  parameter int ACC_WIDTH  = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int MEM_DELAY  = 2
) (
  input  logic                clk,
  input  logic                rst,
  psum_accum_engine_if.slave  bus
);
  localparam int DW   = NUM_KERNEL * BIT_WIDTH;
  localparam int MW   = NUM_KERNEL * ACC_WIDTH;
  localparam int LAST = MEM_DELAY - 1;
  localparam logic [ADDR_WIDTH-1:0] ONE_A = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] base_addr, len, elem_cnt;
  logic [15:0]           num_pass, pass_cnt;
  logic [2:0]            drain_cnt;
  logic                  busy, done;

  // Beat pipeline: lane data and address wait here for the read data.
  logic                  pv    [0:LAST];
  logic                  prd   [0:LAST];
  logic [ADDR_WIDTH-1:0] paddr [0:LAST];
  logic [DW-1:0]         pdat  [0:LAST];

  // Write history, one slot per cycle. Slot 0 is the write issuing this
  // cycle (it drives the memory port); slot j was issued j cycles ago.
  logic                  wv    [0:MEM_DELAY];
  logic [ADDR_WIDTH-1:0] waddr [0:MEM_DELAY];
  logic [MW-1:0]         wdata [0:MEM_DELAY];

  logic                  beat, rden_i;
  logic [ADDR_WIDTH-1:0] beat_addr;
  logic [MW-1:0]         old_dat, sum_dat;
  logic signed [BIT_WIDTH-1:0] lane_in;
  logic signed [ACC_WIDTH-1:0] lane_ext, lane_old, lane_res;
`ifdef PSUM_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  logic signed [ACC_WIDTH:0] lane_wide;
`endif

  assign beat      = (state == RUN) && bus.psum_vld;
  assign beat_addr = base_addr + elem_cnt;
  assign rden_i    = beat && (pass_cnt != 16'd0);

  assign bus.mem_rden   = rden_i;
  assign bus.mem_radd   = rden_i ? beat_addr : '0;
  assign bus.mem_wren   = wv[0];
  assign bus.mem_wadd   = waddr[0];
  assign bus.mem_idat   = wdata[0];
  assign bus.o_busy     = busy;
  assign bus.o_done     = done;
  assign bus.o_pass_cnt = pass_cnt;
  assign bus.dbg_state  = state;

  // Control FSM with registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      base_addr <= '0;
      len       <= '0;
      num_pass  <= '0;
      elem_cnt  <= '0;
      pass_cnt  <= '0;
      drain_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cfg_start) begin
            base_addr <= bus.cfg_base_addr;
            len       <= bus.cfg_len;
            num_pass  <= bus.cfg_num_pass;
            elem_cnt  <= '0;
            pass_cnt  <= '0;
            drain_cnt <= '0;
            if (bus.cfg_len == '0 || bus.cfg_num_pass == 16'd0) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (bus.psum_vld) begin
            if (elem_cnt == len - ONE_A) begin
              elem_cnt <= '0;
              pass_cnt <= pass_cnt + 16'd1;
              if (pass_cnt + 16'd1 == num_pass) state <= DRAIN;
            end else begin
              elem_cnt <= elem_cnt + ONE_A;
            end
          end
        end
        DRAIN: begin
          // The last beat's write lands in the final DRAIN cycle.
          if (drain_cnt == 3'(MEM_DELAY)) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            drain_cnt <= drain_cnt + 3'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Beat pipeline and write history shift every cycle, beat or not, so the
  // history stays aligned to issue cycles across gaps in psum_vld.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MEM_DELAY; i++) begin
        pv[i]    <= 1'b0;
        prd[i]   <= 1'b0;
        paddr[i] <= '0;
        pdat[i]  <= '0;
      end
      for (int j = 0; j <= MEM_DELAY; j++) begin
        wv[j]    <= 1'b0;
        waddr[j] <= '0;
        wdata[j] <= '0;
      end
    end else begin
      pv[0]    <= beat;
      prd[0]   <= rden_i;
      paddr[0] <= beat_addr;
      pdat[0]  <= bus.psum_dat;
      for (int i = 1; i < MEM_DELAY; i++) begin
        pv[i]    <= pv[i-1];
        prd[i]   <= prd[i-1];
        paddr[i] <= paddr[i-1];
        pdat[i]  <= pdat[i-1];
      end
      wv[0]    <= pv[LAST];
      waddr[0] <= paddr[LAST];
      wdata[0] <= sum_dat;
      for (int j = 1; j <= MEM_DELAY; j++) begin
        wv[j]    <= wv[j-1];
        waddr[j] <= waddr[j-1];
        wdata[j] <= wdata[j-1];
      end
    end
  end

  // Old value: zero in pass 0. Otherwise memory data, overridden by the
  // youngest history write to the same address; every history slot was
  // issued at or after the read, so memory could not have returned it.
  always_comb begin
    old_dat  = '0;
    sum_dat  = '0;
    lane_in  = '0;
    lane_ext = '0;
    lane_old = '0;
    lane_res = '0;
`ifdef PSUM_SAT_EN
    lane_wide = '0;
`endif
    if (prd[LAST]) begin
      old_dat = bus.mem_ovld ? bus.mem_odat : '0;
      for (int j = MEM_DELAY; j >= 0; j--) begin
        if (wv[j] && (waddr[j] == paddr[LAST])) old_dat = wdata[j];
      end
    end
    for (int k = 0; k < NUM_KERNEL; k++) begin
      lane_in  = pdat[LAST][k*BIT_WIDTH +: BIT_WIDTH];
      lane_ext = ACC_WIDTH'(lane_in);
      lane_old = old_dat[k*ACC_WIDTH +: ACC_WIDTH];
`ifdef PSUM_SAT_EN
      lane_wide = (ACC_WIDTH+1)'(lane_old) + (ACC_WIDTH+1)'(lane_ext);
      if (lane_wide[ACC_WIDTH] != lane_wide[ACC_WIDTH-1])
        lane_res = lane_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
      else
        lane_res = lane_wide[ACC_WIDTH-1:0];
`else
      lane_res = lane_old + lane_ext;
`endif
      sum_dat[k*ACC_WIDTH +: ACC_WIDTH] = lane_res;
    end
  end
endmodule

// File: tb/tb_psum_accum_engine.sv
`timescale 1ns/1ps
module tb_psum_accum_engine;
  localparam int NK  = 4;
  localparam int BW  = 8;
  localparam int AC  = 16;
  localparam int ADW = 16;
  localparam int MD  = 2;
  localparam int DW  = NK * BW;
  localparam int MW  = NK * AC;
  localparam int EW  = 32 + ADW + MW;
  localparam int RW  = 32 + ADW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] cyc = 32'd0;
  always @(posedge clk) cyc <= cyc + 32'd1;

  psum_accum_engine_if #(.NUM_KERNEL(NK), .BIT_WIDTH(BW), .ACC_WIDTH(AC), .ADDR_WIDTH(ADW)) bus ();

  psum_accum_engine #(
    .NUM_KERNEL(NK), .BIT_WIDTH(BW), .ACC_WIDTH(AC), .ADDR_WIDTH(ADW), .MEM_DELAY(MD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- buffer memory model ----------------
  logic [MW-1:0] mem     [0:65535];
  logic [MW-1:0] rd_pipe [0:MD-1];
  logic          rv_pipe [0:MD-1];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MD; i++) rv_pipe[i] <= 1'b0;
    end else begin
      rv_pipe[0] <= bus.mem_rden;
      rd_pipe[0] <= mem[bus.mem_radd];
      for (int i = 1; i < MD; i++) begin
        rv_pipe[i] <= rv_pipe[i-1];
        rd_pipe[i] <= rd_pipe[i-1];
      end
    end
    if (bus.mem_wren) mem[bus.mem_wadd] <= bus.mem_idat;
  end
  assign bus.mem_odat = rd_pipe[MD-1];
  assign bus.mem_ovld = rv_pipe[MD-1];

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];   // {cycle, addr, data} of expected writes
  logic [RW-1:0] rd_q[$];    // {cycle, addr} of expected reads
  logic [MW-1:0] ref_mem [int];
  int checks = 0;
  int errors = 0;
  int wr_seen = 0;
  int rd_seen = 0;
  logic [EW-1:0] e_wr;
  logic [RW-1:0] e_rd;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_wren) begin
        wr_seen++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL wr_unexpected: cycle %0d addr %h data %h, required no write", cyc, bus.mem_wadd, bus.mem_idat);
        end else begin
          e_wr = exp_q.pop_front();
          if (e_wr != {cyc, bus.mem_wadd, bus.mem_idat}) begin
            errors++;
            $display("FAIL wr_match: got cycle %0d addr %h data %h, required cycle %0d addr %h data %h",
                     cyc, bus.mem_wadd, bus.mem_idat, e_wr[EW-1 -: 32], e_wr[MW +: ADW], e_wr[MW-1:0]);
          end
        end
      end
      if (bus.mem_rden) begin
        rd_seen++;
        checks++;
        if (rd_q.size() == 0) begin
          errors++;
          $display("FAIL rd_unexpected: cycle %0d addr %h, required no read", cyc, bus.mem_radd);
        end else begin
          e_rd = rd_q.pop_front();
          if (e_rd != {cyc, bus.mem_radd}) begin
            errors++;
            $display("FAIL rd_match: got cycle %0d addr %h, required cycle %0d addr %h",
                     cyc, bus.mem_radd, e_rd[RW-1 -: 32], e_rd[ADW-1:0]);
          end
        end
      end
    end
  end

  // ---------------- reference arithmetic ----------------
  function automatic logic [15:0] lane_add(input logic [15:0] a, input logic [15:0] b);
    int s;
    s = int'(signed'(a)) + int'(signed'(b));
`ifdef PSUM_SAT_EN
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
`endif
    return s[15:0];
  endfunction

  function automatic logic [MW-1:0] model_update(input logic [MW-1:0] old, input logic [DW-1:0] d, input bit first);
    logic [MW-1:0] r;
    logic [15:0] ext;
    r = '0;
    for (int k = 0; k < NK; k++) begin
      ext = {{8{d[k*8+7]}}, d[k*8 +: 8]};
      r[k*16 +: 16] = first ? ext : lane_add(old[k*16 +: 16], ext);
    end
    return r;
  endfunction

  // mode 1: overflow ramp (lane0 climbs to +32767 then +1, lane1 falls to
  // -32768 then -1, lanes 2/3 add 1 each beat); otherwise a constant pattern.
  function automatic logic [DW-1:0] beat_pat(input int mode, input int idx, input logic [DW-1:0] pat);
    logic [7:0] l0, l1;
    if (mode == 1) begin
      l0 = (idx < 258) ? 8'd127 : 8'd1;
      l1 = (idx < 256) ? 8'h80 : ((idx < 259) ? 8'h00 : 8'hFF);
      return {8'd1, 8'd1, l1, l0};
    end
    return pat;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [MW-1:0] got, input logic [MW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  task automatic wait_done(input logic [31:0] exp_cyc);
    int pulses;
    logic [31:0] first;
    bit busy_at_done;
    pulses = 0;
    first = 32'hFFFF_FFFF;
    busy_at_done = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (bus.o_done) begin
        if (pulses == 0) first = cyc;
        pulses++;
        if (bus.o_busy) busy_at_done = 1'b1;
      end
    end
    check("done_pulses", MW'(pulses), MW'(1));
    check("done_cycle", MW'(first), MW'(exp_cyc));
    check("busy_at_done", MW'(busy_at_done), MW'(0));
    step();
  endtask

  task automatic run_job(input logic [15:0] base, input logic [15:0] len, input logic [15:0] npass,
                         input int mode, input logic [DW-1:0] pat, input int gap,
                         input int inject_at, input int abort_at);
    int beat;
    int total;
    logic [31:0] start_cyc, last_cyc;
    logic [15:0] a;
    logic [MW-1:0] nv, ov;
    total = int'(len) * int'(npass);
    bus.cfg_base_addr = base;
    bus.cfg_len       = len;
    bus.cfg_num_pass  = npass;
    bus.cfg_start     = 1'b1;
    start_cyc = cyc;
    last_cyc  = cyc;
    step();
    bus.cfg_start = 1'b0;
    beat = 0;
    for (int p = 0; p < int'(npass); p++) begin
      for (int e = 0; e < int'(len); e++) begin
        if (beat == abort_at) begin
          rst = 1'b1;
          bus.psum_vld = 1'b0;
          #1;
          check("rst_outputs", MW'({bus.mem_wren, bus.mem_rden, bus.o_busy, bus.o_done, bus.o_pass_cnt,
                                   bus.mem_wadd, bus.mem_radd}), '0);
          check("rst_wdata", bus.mem_idat, '0);
          check("rst_state", MW'(bus.dbg_state), '0);
          exp_q.delete();
          rd_q.delete();
          step();
          rst = 1'b0;
          return;
        end
        if (beat == inject_at) begin
          bus.cfg_start     = 1'b1;
          bus.cfg_base_addr = 16'h0F00;
          bus.cfg_len       = 16'd9;
          bus.cfg_num_pass  = 16'd1;
        end
        check("pass_cnt", MW'(bus.o_pass_cnt), MW'(p));
        if (beat == 0) check("busy_run", MW'(bus.o_busy), MW'(1));
        a = base + e[15:0];
        bus.psum_dat = beat_pat(mode, beat, pat);
        bus.psum_vld = 1'b1;
        if (p > 0) rd_q.push_back({cyc, a});
        ov = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0;
        nv = model_update(ov, bus.psum_dat, p == 0);
        ref_mem[int'(a)] = nv;
        exp_q.push_back({cyc + 32'(MD + 1), a, nv});
        last_cyc = cyc;
        step();
        bus.cfg_start     = 1'b0;
        bus.cfg_base_addr = base;
        bus.cfg_len       = len;
        bus.cfg_num_pass  = npass;
        bus.psum_vld      = 1'b0;
        beat++;
        if (beat < total) repeat (gap) step();
      end
    end
    if (total == 0) wait_done(start_cyc + 32'd1);
    else            wait_done(last_cyc + 32'(MD + 2));
  endtask

  // ---------------- stimulus ----------------
  int wr_snap, rd_snap;

  initial begin
    bus.cfg_start     = 1'b0;
    bus.cfg_base_addr = '0;
    bus.cfg_len       = '0;
    bus.cfg_num_pass  = '0;
    bus.psum_dat      = '0;
    bus.psum_vld      = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    check("reset_outputs", MW'({bus.mem_wren, bus.mem_rden, bus.o_busy, bus.o_done, bus.o_pass_cnt,
                               bus.mem_wadd, bus.mem_radd}), '0);
    check("reset_state", MW'(bus.dbg_state), '0);
    rst = 1'b0;
    step();

    // zero-init single pass
    run_job(16'h0010, 16'd3, 16'd1, 0, 32'h05050505, 0, -1, -1);
    for (int i = 0; i < 3; i++) check("zero_init", mem[16'h0010 + i], 64'h0005_0005_0005_0005);

    // accumulate over 3 passes, with a stray cfg_start mid-run
    run_job(16'h0040, 16'd4, 16'd3, 0, 32'hFF030201, 0, 5, -1);
    for (int i = 0; i < 4; i++) check("accumulate", mem[16'h0040 + i], 64'hFFFD_0009_0006_0003);
    check("no_stray_job", MW'(exp_q.size() + rd_q.size()), '0);

    // forwarding: len=1 back-to-back, then len=2 with gaps
    run_job(16'h0080, 16'd1, 16'd6, 0, 32'h00000002, 0, -1, -1);
    check("fwd_len1", mem[16'h0080], 64'h0000_0000_0000_000C);
    run_job(16'h0090, 16'd2, 16'd3, 0, 32'h00000002, 1, -1, -1);
    check("fwd_len2_a", mem[16'h0090], 64'h0000_0000_0000_0006);
    check("fwd_len2_b", mem[16'h0091], 64'h0000_0000_0000_0006);

    // overflow ramp
    run_job(16'h00A0, 16'd1, 16'd260, 1, 32'h0, 0, -1, -1);
`ifdef PSUM_SAT_EN
    check("overflow_sat", mem[16'h00A0], 64'h0104_0104_8000_7FFF);
`else
    check("overflow_wrap", mem[16'h00A0], 64'h0104_0104_7FFF_8000);
`endif

    // empty jobs: no memory traffic
    wr_snap = wr_seen;
    rd_snap = rd_seen;
    run_job(16'h0100, 16'd0, 16'd3, 0, 32'h01010101, 0, -1, -1);
    run_job(16'h0100, 16'd5, 16'd0, 0, 32'h01010101, 0, -1, -1);
    check("empty_no_traffic", MW'((wr_seen - wr_snap) + (rd_seen - rd_snap)), '0);

    // address wrap-around
    run_job(16'hFFFF, 16'd2, 16'd2, 0, 32'h01020304, 0, -1, -1);
    check("wrap_ffff", mem[16'hFFFF], 64'h0002_0004_0006_0008);
    check("wrap_0000", mem[16'h0000], 64'h0002_0004_0006_0008);

    // beats while idle are ignored
    wr_snap = wr_seen;
    bus.psum_dat = 32'h7F7F7F7F;
    bus.psum_vld = 1'b1;
    repeat (4) step();
    bus.psum_vld = 1'b0;
    repeat (4) step();
    check("idle_ignore", MW'(wr_seen - wr_snap), '0);

    // reset during pass 1, then a fresh job
    run_job(16'h0300, 16'd4, 16'd3, 0, 32'h01010101, 0, -1, 6);
    wr_snap = wr_seen;
    repeat (8) step();
    check("no_wr_after_rst", MW'(wr_seen - wr_snap), '0);
    run_job(16'h0400, 16'd2, 16'd2, 0, 32'hFF030201, 0, -1, -1);
    check("fresh_a", mem[16'h0400], 64'hFFFE_0006_0004_0002);
    check("fresh_b", mem[16'h0401], 64'hFFFE_0006_0004_0002);

    repeat (4) step();
    check("queues_empty", MW'(exp_q.size() + rd_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/psum_accum_engine.md
Name: psum_accum_engine

Overview:
Parametrised partial-sum accumulator for the conv datapath. It takes NUM_KERNEL lanes of partial sums per beat and performs a read-modify-write into the psum buffer memory over cfg_num_pass passes of cfg_len beats. Pass 0 overwrites memory; later passes accumulate onto it. It replaces fixed 4-kernel, 8-bit accumulation with configurable lane count, accumulator width and memory latency, and forwards in-flight writes so short passes never read stale data.

Parameters:
NUM_KERNEL, 4, number of psum lanes (1..16)
BIT_WIDTH, 8, signed input lane width
ACC_WIDTH, 16, signed accumulator lane width (>= BIT_WIDTH)
ADDR_WIDTH, 16, memory address width
MEM_DELAY, 2, read latency in cycles from rd_en to rdata valid (1..4)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
cfg_start  in  1  one-cycle start pulse; cfg_* sampled this cycle
cfg_base_addr  in  ADDR_WIDTH  first buffer address
cfg_len  in  ADDR_WIDTH  beats per pass
cfg_num_pass  in  16  number of passes
psum_dat  in  NUM_KERNEL*BIT_WIDTH  lane k at bits [k*BIT_WIDTH +: BIT_WIDTH]
psum_vld  in  1  beat valid (no backpressure)
mem_radd  out  ADDR_WIDTH  read address
mem_rden  out  1  read enable
mem_odat  in  NUM_KERNEL*ACC_WIDTH  read data
mem_ovld  in  1  read data valid, exactly MEM_DELAY cycles after mem_rden
mem_wadd  out  ADDR_WIDTH  write address
mem_wren  out  1  write enable
mem_idat  out  NUM_KERNEL*ACC_WIDTH  write data
o_busy  out  1  high from start until done
o_done  out  1  one-cycle completion pulse
o_pass_cnt  out  16  current pass index (debug)

Behaviour:
- Reset values: all outputs 0; FSM IDLE; counters 0; pipeline valids cleared. Reset mid-run aborts immediately with no further writes.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: cfg_start latches config and enters RUN with o_busy=1. If cfg_len==0 or cfg_num_pass==0, go to DONE with no memory access. psum_vld is ignored in IDLE, DRAIN and DONE.
- cfg_start while not in IDLE is ignored.
- RUN, per psum_vld beat:
  - Beat address = base + elem_cnt, with ADDR_WIDTH wrap-around.
  - elem_cnt increments and wraps to 0 at cfg_len-1; pass_cnt increments on that wrap.
  - After the last beat of the last pass, enter DRAIN.
  - mem_rden is asserted in the beat cycle only when pass_cnt>0, with mem_radd set to the beat address.
- Write timing: a beat accepted at cycle t produces mem_wren at cycle t+MEM_DELAY+1, in every pass.
  - Lane data and address travel through a MEM_DELAY-deep pipeline.
  - The sum is registered one cycle after read data returns.
- Arithmetic, per lane, with ACC_WIDTH two's complement:
  - Input lanes are sign-extended to ACC_WIDTH.
  - Pass 0: wdata = ext(psum).
  - Pass >0: wdata = old + ext(psum), wrapping on overflow unless PSUM_SAT_EN is defined.
- Forwarding (correctness for cfg_len <= MEM_DELAY+1):
  - Memory returns the pre-write value when a read and write to the same address fall in the same cycle.
  - The block keeps an (addr, data) history of the last MEM_DELAY+1 writes, including the sum being registered this cycle.
  - When read data for address A returns, old = data of the most recent write to A issued at or after the read's issue cycle; otherwise old = mem_odat.
  - Gaps between psum_vld beats must not break forwarding; the history is indexed by issue cycle, not by beat.
- DRAIN: wait MEM_DELAY+1 cycles until the pipeline is empty, then go to DONE.
- DONE: o_done=1 for one cycle, o_busy=0, return to IDLE.
- mem_ovld asserted with no matching outstanding read is ignored.

Optional Feature:
PSUM_SAT_EN
- Defined: each lane add saturates to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1], and forwarded values are the saturated values.
- Undefined: plain modulo-2^ACC_WIDTH add, with no saturation logic generated.

Test Plan:
- Zero-init: NUM_KERNEL=4, base=0x10, len=3, num_pass=1, lanes=5 -> writes at 0x10..0x12, data 0x0005 per lane, mem_wren 3 cycles after each beat (MEM_DELAY=2), no mem_rden, o_done after DRAIN.
- Accumulate: len=4, num_pass=3, each beat lanes {1,2,3,-1} -> final memory per address lanes {3,6,9,-3}; o_done a single pulse.
- Forwarding hazard: len=1, num_pass=6, back-to-back beats lane0=+2 -> address base holds 12 (no stale reads); repeat with len=2 and 1-cycle gaps -> 6 at each address.
- Overflow: ACC_WIDTH=16, prior 0x7FFF + 1 -> 0x8000 without PSUM_SAT_EN, 0x7FFF with it; -32768 + (-1) -> 0x7FFF wrap / 0x8000 saturate.
- Boundaries: cfg_len=0 -> o_done 1 cycle later with no memory traffic; base=0xFFFF, len=2 -> addresses 0xFFFF then 0x0000; cfg_start during RUN is ignored.
- Reset mid-run: assert rst during pass 1 -> all outputs 0 the same cycle, no mem_wren afterwards, and a fresh start works normally.
